frame_rotator: RTL

Parametrised square-frame rotator for the image-rotation pipeline. It accepts one raster-order frame of IMG_DIM x IMG_DIM pixels over a valid/ready stream and buffers it in on-chip RAM. It then emits the frame rotated by 0/90/180/270 degrees clockwise, with optional horizontal mirror, in raster order. It sits between the pixel source and the greyscale/output stage, replacing the fixed 64x64, 24-bit, no-backpressure reader.

---
 rtl/rot_pkg.sv | 27 ++
 rtl/frame_rotator_if.sv | 31 +++
 rtl/rot_addr_gen.sv | 50 +++++
 rtl/frame_rotator.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// ============================================================================
// rot_pkg : shared types and helpers for the frame_rotator block
// Rev 1.0
// ============================================================================
`default_nettype none

package rot_pkg;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_mode_e;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic int idx_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_rotator_if.sv
// ============================================================================
// frame_rotator_if : pixel input/output stream bundle for frame_rotator
// Rev 1.0
// ============================================================================
`default_nettype none

interface frame_rotator_if #(
  parameter int PIX_W = 24
);
  logic             i_pix_valid;
  logic [PIX_W-1:0] i_pix_data;
  logic             o_in_ready;
  logic             o_pix_valid;
  logic [PIX_W-1:0] o_pix_data;
  logic             i_out_ready;
  logic             o_line_last;
  logic             o_frame_last;

  // master: pixel source plus downstream sink; slave: the rotator
  modport master (
    output i_pix_valid, i_pix_data, i_out_ready,
    input  o_in_ready, o_pix_valid, o_pix_data, o_line_last, o_frame_last
  );

  modport slave (
    input  i_pix_valid, i_pix_data, i_out_ready,
    output o_in_ready, o_pix_valid, o_pix_data, o_line_last, o_frame_last
  );
endinterface

`default_nettype wire

// File: rtl/rot_addr_gen.sv
// ============================================================================
// rot_addr_gen : maps an output raster position to its source pixel position
// Rev 1.0
// ============================================================================
`default_nettype none

module rot_addr_gen
  import rot_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] row,
  input  logic [ADDR_W-1:0] col,
  input  rot_mode_e         mode,
  input  logic              mirror,
  output logic [ADDR_W-1:0] src_row,
  output logic [ADDR_W-1:0] src_col
);

  localparam logic [ADDR_W-1:0] N_MAX = '1;

  logic [ADDR_W-1:0] col_eff;

  always_comb begin
    col_eff = mirror ? (N_MAX - col) : col;
    src_row = row;
    src_col = col_eff;
    case (mode)
      ROT_0: begin
        src_row = row;
        src_col = col_eff;
      end
      ROT_90: begin
        src_row = N_MAX - col_eff;
        src_col = row;
      end
      ROT_180: begin
        src_row = N_MAX - row;
        src_col = N_MAX - col_eff;
      end
      ROT_270: begin
        src_row = col_eff;
        src_col = N_MAX - row;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/frame_rotator.sv
// ============================================================================
// frame_rotator : buffers one square frame, emits it rotated/mirrored in raster
// order. Optional PING_PONG_EN adds a second bank to overlap load and emit.
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_rotator
  import rot_pkg::*;
#(
  parameter int PIX_W   = 24,
  parameter int IMG_DIM = 64,
  parameter int ADDR_W  = idx_w(IMG_DIM)
) (
  input  logic                  axi_clk,
  input  logic                  reset,
  input  logic [1:0]            i_rot_mode,
  input  logic                  i_mirror,
  frame_rotator_if.slave        bus,
  output logic                  o_busy
);

`ifdef PING_PONG_EN
  localparam int BANKS = 2;
  localparam bit SWAP  = 1'b1;
`else
  localparam int BANKS = 1;
  localparam bit SWAP  = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] N_MAX   = '1;
  localparam int                RAM_AW  = $clog2(BANKS) + 2 * ADDR_W;
  localparam int                RAM_DEP = 1 << RAM_AW;

  state_e            bank_q [2];
  state_e            bank_d [2];
  rot_mode_e         mode_q [2];
  logic              mirror_q [2];
  logic              rd_done [2];
  logic              wr_bank, rd_bank, out_bank;
  logic [ADDR_W-1:0] wr_row, wr_col, rd_row, rd_col, src_row, src_col;
  logic [RAM_AW-1:0] waddr, raddr;

  logic [PIX_W-1:0]  mem [RAM_DEP];
  logic [PIX_W-1:0]  rdata;
  logic              pend_valid, pend_line, pend_frame;

  logic [PIX_W-1:0]  fifo_data [2];
  logic              fifo_line [2];
  logic              fifo_frame [2];
  logic              wptr, rptr;
  logic [1:0]        count;

  logic              in_fire, load_done, issue, pop, last_pop;
  logic [2:0]        occ;

  assign bus.o_in_ready   = (bank_q[wr_bank] == LOAD);
  assign in_fire          = bus.i_pix_valid && bus.o_in_ready;
  assign load_done        = in_fire && (wr_row == N_MAX) && (wr_col == N_MAX);

  assign bus.o_pix_valid  = (count != 2'd0);
  assign bus.o_pix_data   = fifo_data[rptr];
  assign bus.o_line_last  = bus.o_pix_valid && fifo_line[rptr];
  assign bus.o_frame_last = bus.o_pix_valid && fifo_frame[rptr];
  assign pop              = bus.o_pix_valid && bus.i_out_ready;
  assign last_pop         = pop && fifo_frame[rptr];

  // Issue only if the read landing next cycle still fits in the 2-entry skid
  assign occ   = {1'b0, count} + {2'b00, pend_valid};
  assign issue = (bank_q[rd_bank] == EMIT) && !rd_done[rd_bank] &&
                 (occ <= (3'd1 + {2'b00, pop}));

  assign o_busy = (bank_q[0] != LOAD) || (bank_q[1] != LOAD) ||
                  (wr_row != '0) || (wr_col != '0);

  assign waddr = RAM_AW'({wr_bank, wr_row, wr_col});
  assign raddr = RAM_AW'({rd_bank, src_row, src_col});

  rot_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .row     (rd_row),
    .col     (rd_col),
    .mode    (mode_q[rd_bank]),
    .mirror  (mirror_q[rd_bank]),
    .src_row (src_row),
    .src_col (src_col)
  );

  always_ff @(posedge axi_clk) begin
    if (reset) bank_q <= '{LOAD, LOAD};
    else       bank_q <= bank_d;
  end

  always_comb begin
    bank_d = bank_q;
    if (load_done) bank_d[wr_bank]  = EMIT;
    if (last_pop)  bank_d[out_bank] = LOAD;
  end

  always_ff @(posedge axi_clk) begin
    if (reset) begin
      wr_row   <= '0;
      wr_col   <= '0;
      wr_bank  <= 1'b0;
      mode_q   <= '{ROT_0, ROT_0};
      mirror_q <= '{1'b0, 1'b0};
    end else if (in_fire) begin
      wr_col <= wr_col + 1'b1;
      if (wr_col == N_MAX) wr_row <= wr_row + 1'b1;
      if (load_done) wr_bank <= wr_bank ^ SWAP;
      if ((wr_row == '0) && (wr_col == '0)) begin
        mode_q[wr_bank]   <= rot_mode_e'(i_rot_mode);
        mirror_q[wr_bank] <= i_mirror;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (in_fire) mem[waddr] <= bus.i_pix_data;
    if (issue)   rdata      <= mem[raddr];
  end

  always_ff @(posedge axi_clk) begin
    if (reset) begin
      rd_row     <= '0;
      rd_col     <= '0;
      rd_bank    <= 1'b0;
      out_bank   <= 1'b0;
      rd_done    <= '{1'b0, 1'b0};
      pend_valid <= 1'b0;
      pend_line  <= 1'b0;
      pend_frame <= 1'b0;
    end else begin
      pend_valid <= issue;
      pend_line  <= issue && (rd_col == N_MAX);
      pend_frame <= issue && (rd_col == N_MAX) && (rd_row == N_MAX);
      if (issue) begin
        rd_col <= rd_col + 1'b1;
        if (rd_col == N_MAX) rd_row <= rd_row + 1'b1;
        if ((rd_col == N_MAX) && (rd_row == N_MAX)) begin
          rd_done[rd_bank] <= 1'b1;
          rd_bank          <= rd_bank ^ SWAP;
        end
      end
      if (last_pop) begin
        rd_done[out_bank] <= 1'b0;
        out_bank          <= out_bank ^ SWAP;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (reset) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i]  <= '0;
        fifo_line[i]  <= 1'b0;
        fifo_frame[i] <= 1'b0;
      end
    end else begin
      if (pend_valid) begin
        fifo_data[wptr]  <= rdata;
        fifo_line[wptr]  <= pend_line;
        fifo_frame[wptr] <= pend_frame;
        wptr             <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, pend_valid} - {1'b0, pop};
    end
  end

endmodule

`default_nettype wire
